// File: rtl/sprite_pkg.sv
// Shared raster constants, colour type and brightness scaling
// for the scaled sprite renderer.
package sprite_pkg;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int H_TOTAL  = 800;
  localparam int V_TOTAL  = 525;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // Full scale (15) adds c>>3 back to offset the /16 truncation.
  function automatic logic [3:0] fade_ch(
    input logic [3:0] c,
    input logic [3:0] f
  );
    logic [7:0] p;
    p = {4'd0, c} * {4'd0, f};
    return p[7:4] + ((f == 4'hF) ? {3'd0, c[3]} : 4'd0);
  endfunction

  function automatic rgb444_t fade_rgb(
    input rgb444_t    c,
    input logic [3:0] f
  );
    rgb444_t o;
    o.r = fade_ch(c.r, f);
    o.g = fade_ch(c.g, f);
    o.b = fade_ch(c.b, f);
    return o;
  endfunction

endpackage

// File: rtl/scaled_sprite_renderer_dda_axis.sv
// One scaling axis: error-accumulator stepping of a source index,
// giving floor(k*SRC/DST) after k steps, saturating at SRC-1.
module dda_axis
  import sprite_pkg::*;
#(
  parameter int SRC = 185,
  parameter int DST = 640,
  parameter int IW  = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          step_i,
  output logic [IW-1:0] idx_o,
  output logic          stepped_o
);

  localparam int AW = $clog2(SRC + DST);

  logic [AW-1:0] acc_q, acc_d, acc_sum;
  logic [IW-1:0] idx_q, idx_d;

  // idx_o is the value for the current sample, state keeps it
  always_comb begin
    acc_sum   = acc_q + AW'(SRC);
    acc_d     = acc_q;
    idx_d     = idx_q;
    stepped_o = 1'b0;
    if (start_i) begin
      acc_d = '0;
      idx_d = '0;
    end else if (step_i) begin
      if (acc_sum >= AW'(DST)) begin
        acc_d = acc_sum - AW'(DST);
        if (idx_q != IW'(SRC - 1)) begin
          idx_d     = idx_q + 1'b1;
          stepped_o = 1'b1;
        end
      end else begin
        acc_d = acc_sum;
      end
    end
  end

  assign idx_o = idx_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q <= '0;
      idx_q <= '0;
    end else begin
      acc_q <= acc_d;
      idx_q <= idx_d;
    end
  end

endmodule

// File: rtl/scaled_sprite_renderer.sv
// Scales a palettised ROM image into a screen window with
// transparency key, background pass-through and fade.
module scaled_sprite_renderer
  import sprite_pkg::*;
#(
  parameter int SRC_W     = 185,
  parameter int SRC_H     = 131,
  parameter int DST_W     = 640,
  parameter int DST_H     = 480,
  parameter int IDX_W     = 3,
  parameter int ADDR_W    = 15,
  parameter int TRANS_IDX = 0
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic [9:0]        win_x0,
  input  logic [9:0]        win_y0,
  input  logic              trans_en,
  input  logic [3:0]        fade,
  input  logic [11:0]       bg_rgb,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [IDX_W-1:0]  pal_index,
  input  logic [11:0]       pal_rgb,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              sprite_hit
);

  localparam int XW = (SRC_W > 1) ? $clog2(SRC_W) : 1;
  localparam int YW = (SRC_H > 1) ? $clog2(SRC_H) : 1;

  logic [9:0]        wx_q, wx_d, wy_q, wy_d;
  logic [3:0]        fade_q, fade_d;
  logic [9:0]        y_q;
  logic              yv_q;
  logic [ADDR_W-1:0] row_q, row_d, addr_q, addr_d;
  logic              v0_q, in0_q, v1_q, in1_q;
  rgb444_t           rgb_q, rgb_d;
  logic              hit_q, hit_d;

  logic              frame_start, line_chg;
  logic [9:0]        inx, iny;
  logic              in_x, in_y, x_start;
  logic              y_start, y_step, y_stepped, x_stepped;
  logic [XW-1:0]     src_x;
  logic [YW-1:0]     src_y;
  logic              unused;

  // Window/fade take effect on the frame-start pixel itself
  assign frame_start = (DrawX == 10'd0) && (DrawY == 10'd0);
  assign wx_d   = frame_start ? win_x0 : wx_q;
  assign wy_d   = frame_start ? win_y0 : wy_q;
  assign fade_d = frame_start ? fade : fade_q;

  assign inx  = DrawX - wx_d;
  assign iny  = DrawY - wy_d;
  assign in_x = {1'b0, inx} < 11'(DST_W);
  assign in_y = {1'b0, iny} < 11'(DST_H);

  assign x_start  = (inx == 10'd0);
  assign line_chg = yv_q && (DrawY != y_q);
  assign y_start  = line_chg && (iny == 10'd0);
  assign y_step   = line_chg && in_y;

  dda_axis #(
    .SRC (SRC_W),
    .DST (DST_W),
    .IW  (XW)
  ) u_dda_x (
    .clk_i     (vga_clk),
    .rst_i     (reset),
    .start_i   (x_start),
    .step_i    (in_x),
    .idx_o     (src_x),
    .stepped_o (x_stepped)
  );

  dda_axis #(
    .SRC (SRC_H),
    .DST (DST_H),
    .IW  (YW)
  ) u_dda_y (
    .clk_i     (vga_clk),
    .rst_i     (reset),
    .start_i   (y_start),
    .step_i    (y_step),
    .idx_o     (src_y),
    .stepped_o (y_stepped)
  );

  assign unused = ^{src_y, x_stepped};

  // Row base follows src_y by repeated addition of the row pitch
  always_comb begin
    row_d = row_q;
    if (y_start) begin
      row_d = '0;
    end else if (y_stepped) begin
      row_d = row_q + ADDR_W'(SRC_W);
    end
    addr_d = row_d + ADDR_W'(src_x);
  end

  assign rom_addr  = addr_q;
  assign pal_index = rom_q;

  always_comb begin
    rgb_d = '0;
    hit_d = 1'b0;
    if (v1_q) begin
      if (!in1_q || (trans_en && rom_q == IDX_W'(TRANS_IDX))) begin
        rgb_d = rgb444_t'(bg_rgb);
      end else begin
        rgb_d = fade_rgb(rgb444_t'(pal_rgb), fade_q);
        hit_d = 1'b1;
      end
    end
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      wx_q   <= '0;
      wy_q   <= '0;
      fade_q <= 4'hF;
      y_q    <= '0;
      yv_q   <= 1'b0;
      row_q  <= '0;
      addr_q <= '0;
      v0_q   <= 1'b0;
      in0_q  <= 1'b0;
      v1_q   <= 1'b0;
      in1_q  <= 1'b0;
      rgb_q  <= '0;
      hit_q  <= 1'b0;
    end else begin
      wx_q   <= wx_d;
      wy_q   <= wy_d;
      fade_q <= fade_d;
      y_q    <= DrawY;
      yv_q   <= 1'b1;
      row_q  <= row_d;
      addr_q <= addr_d;
      v0_q   <= blank;
      in0_q  <= in_x && in_y;
      v1_q   <= v0_q;
      in1_q  <= in0_q;
      rgb_q  <= rgb_d;
      hit_q  <= hit_d;
    end
  end

  assign red        = rgb_q.r;
  assign green      = rgb_q.g;
  assign blue       = rgb_q.b;
  assign sprite_hit = hit_q;

endmodule

// File: tb/tb_scaled_sprite_renderer.sv
// Scoreboard bench: raster stimulus with a step-count scaling model,
// sync ROM and palette models, monitor checks address and colour.
module tb_scaled_sprite_renderer;

  localparam int SW = 185;
  localparam int SH = 131;
  localparam int DW = 640;
  localparam int DH = 480;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  DrawX = '0, DrawY = '0;
  logic [9:0]  win_x0 = '0, win_y0 = '0;
  logic        blank = 1'b0, trans_en = 1'b0;
  logic [3:0]  fade = 4'hF;
  logic [11:0] bg_rgb = 12'h123;
  logic [14:0] rom_addr;
  logic [2:0]  rom_q = '0;
  logic [2:0]  pal_index;
  logic [11:0] pal_rgb;
  logic [3:0]  red, green, blue;
  logic        sprite_hit;

  logic [2:0]  rom [0:32767];
  logic [11:0] pal [0:7];

  always #5 clk = ~clk;

  always @(posedge clk) rom_q <= rom[rom_addr];
  assign pal_rgb = pal[pal_index];

  scaled_sprite_renderer dut (
    .vga_clk    (clk),
    .reset      (rst),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .blank      (blank),
    .win_x0     (win_x0),
    .win_y0     (win_y0),
    .trans_en   (trans_en),
    .fade       (fade),
    .bg_rgb     (bg_rgb),
    .rom_addr   (rom_addr),
    .rom_q      (rom_q),
    .pal_index  (pal_index),
    .pal_rgb    (pal_rgb),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .sprite_hit (sprite_hit)
  );

  typedef struct {
    int          due;
    logic [14:0] addr;
  } aexp_t;

  typedef struct {
    int          due;
    logic [11:0] rgb;
    logic        hit;
  } oexp_t;

  aexp_t aq[$];
  oexp_t oq[$];

  int cyc = 0;
  int nvec = 0;
  int nerr = 0;
  bit done = 0;
  bit drained = 0;

  int wxs = 0, wys = 0, fs = 15;
  int kx = 0, ky = 0, py = 0;
  bit pv = 0;
  bit rnd_blank = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always begin
    aexp_t ae;
    oexp_t oe;
    @(negedge clk or posedge rst);
    #1;
    if (rst) begin
      nvec++;
      if ({red, green, blue, sprite_hit, rom_addr} !== '0) begin
        nerr++;
        $display("FAIL rst_out rgb=%h hit=%b addr=%0d want all 0",
                 {red, green, blue}, sprite_hit, rom_addr);
      end
    end else begin
      while (aq.size() > 0 && aq[0].due <= cyc) begin
        ae = aq.pop_front();
        nvec++;
        if (rom_addr !== ae.addr) begin
          nerr++;
          $display("FAIL addr cyc=%0d got %0d want %0d",
                   cyc, rom_addr, ae.addr);
        end
      end
      while (oq.size() > 0 && oq[0].due <= cyc) begin
        oe = oq.pop_front();
        nvec++;
        if ({red, green, blue} !== oe.rgb || sprite_hit !== oe.hit) begin
          nerr++;
          $display("FAIL rgb cyc=%0d got %h/%b want %h/%b",
                   cyc, {red, green, blue}, sprite_hit, oe.rgb, oe.hit);
        end
      end
      if (done && !drained) begin
        drained = 1;
        nvec++;
        if (aq.size() + oq.size() != 0) begin
          nerr++;
          $display("FAIL drain pending=%0d want 0", aq.size() + oq.size());
        end
      end
    end
  end

  function automatic logic [3:0] fch(input int c, input int f);
    int v;
    v = (c * f) / 16 + ((f == 15) ? c / 8 : 0);
    return v[3:0];
  endfunction

  task automatic px(input int x, input int y, input bit b);
    int inx, iny, sx, sy, a, idx;
    bit ix, iy;
    aexp_t ae;
    oexp_t oe;
    logic [11:0] p;
    @(negedge clk);
    rst = 1'b0;
    DrawX = 10'(x);
    DrawY = 10'(y);
    blank = b;
    if (x == 0 && y == 0) begin
      wxs = int'(win_x0);
      wys = int'(win_y0);
      fs  = int'(fade);
    end
    inx = (x - wxs) & 1023;
    iny = (y - wys) & 1023;
    ix = inx < DW;
    iy = iny < DH;
    if (pv && y != py) begin
      if (iny == 0) ky = 0;
      else if (iy) ky++;
    end
    pv = 1;
    py = y;
    if (inx == 0) kx = 0;
    else if (ix) kx++;
    sx = kx * SW / DW;
    if (sx > SW - 1) sx = SW - 1;
    sy = ky * SH / DH;
    if (sy > SH - 1) sy = SH - 1;
    a = sy * SW + sx;
    idx = int'(rom[a]);
    if (ix && iy) begin
      ae.due = cyc + 1;
      ae.addr = 15'(a);
      aq.push_back(ae);
    end
    oe.due = cyc + 3;
    oe.rgb = '0;
    oe.hit = 1'b0;
    if (b) begin
      if (!(ix && iy) || (trans_en && idx == 0)) begin
        oe.rgb = bg_rgb;
      end else begin
        p = pal[idx];
        oe.rgb = {fch(p[11:8], fs), fch(p[7:4], fs), fch(p[3:0], fs)};
        oe.hit = 1'b1;
      end
    end
    oq.push_back(oe);
  endtask

  task automatic line(input int y, input int xs, input int xe);
    for (int x = xs; x <= xe; x++)
      px(x, y, y < 480 && !(rnd_blank && $urandom_range(15) == 0));
    for (int x = 640; x < 643; x++)
      px(x, y, 1'b0);
  endtask

  task automatic frame(input int y0, input int y1,
                       input int chg, input int nwx);
    int xs, xe, m;
    for (int y = y0; y <= y1; y++) begin
      if (y == chg) win_x0 = 10'(nwx);
      m = (wxs < int'(win_x0)) ? wxs : int'(win_x0);
      xs = (y == 0) ? 0 : ((m > 4) ? m - 4 : 0);
      if (y == 0 || y == 479 || $urandom_range(63) == 0) xe = 639;
      else xe = (m + 20 > 639) ? 639 : m + 20;
      line(y, xs, xe);
    end
  endtask

  task automatic mid_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    DrawX = 10'd300;
    aq.delete();
    oq.delete();
    wxs = 0;
    wys = 0;
    fs = 15;
    kx = 0;
    ky = 0;
    pv = 0;
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) rom[i] = 3'($urandom_range(7));
    for (int i = 0; i < 8; i++) pal[i] = 12'($urandom);
    rom[0] = 3'd5;
    rom[1] = 3'd0;
    rom[2] = 3'd0;
    pal[5] = 12'hF80;
    pal[0] = 12'h5AC;

    repeat (3) @(negedge clk);

    win_x0 = 10'd0; win_y0 = 10'd0; fade = 4'd15;
    trans_en = 1'b0; bg_rgb = 12'h123;
    frame(0, 479, -1, 0);

    win_x0 = 10'd100; win_y0 = 10'd20; fade = 4'd8;
    trans_en = 1'b1;
    frame(0, 60, 10, 200);

    fade = 4'd0;
    trans_en = 1'b0;
    frame(0, 50, -1, 0);

    win_x0 = 10'd30; win_y0 = 10'd10; fade = 4'd15;
    trans_en = 1'b1;
    frame(0, 14, -1, 0);
    for (int x = 26; x < 300; x++) px(x, 15, 1'b1);
    mid_reset();
    for (int x = 301; x <= 320; x++) px(x, 15, 1'b1);
    for (int x = 640; x < 643; x++) px(x, 15, 1'b0);
    frame(16, 40, -1, 0);

    rnd_blank = 1;
    for (int f = 0; f < 3; f++) begin
      win_x0 = 10'($urandom_range(120));
      win_y0 = 10'($urandom_range(20));
      fade = 4'($urandom_range(15));
      trans_en = 1'($urandom_range(1));
      bg_rgb = 12'($urandom);
      frame(0, 50, -1, 0);
    end

    repeat (4) @(negedge clk);
    done = 1;
    repeat (2) @(negedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
